// File: rtl/axi4_lite_initiator.sv
// axi4_lite_initiator: single-outstanding AXI4-lite master driven by a cmd/rsp handshake.
// Ports: clk/resetn (async active-low); cmd_* command in (valid/ready, write, insn, addr, wdata, wstrb);
// rsp_* response out (valid/ready, write, rdata, timeout); mem_axi_* AXI4-lite AW/W/B/AR/R channels.
// Optional: define AXI_INIT_TIMEOUT_EN to enable a TIMEOUT_CYCLES watchdog that aborts stuck transactions.
module axi4_lite_initiator #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic        cmd_insn,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        rsp_timeout,
    output logic        mem_axi_awvalid,
    input  logic        mem_axi_awready,
    output logic [31:0] mem_axi_awaddr,
    output logic [2:0]  mem_axi_awprot,
    output logic        mem_axi_wvalid,
    input  logic        mem_axi_wready,
    output logic [31:0] mem_axi_wdata,
    output logic [3:0]  mem_axi_wstrb,
    input  logic        mem_axi_bvalid,
    output logic        mem_axi_bready,
    output logic        mem_axi_arvalid,
    input  logic        mem_axi_arready,
    output logic [31:0] mem_axi_araddr,
    output logic [2:0]  mem_axi_arprot,
    input  logic        mem_axi_rvalid,
    output logic        mem_axi_rready,
    input  logic [31:0] mem_axi_rdata
);
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD, RSP} state_t;

    state_t      state_q, state_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] araddr_q, araddr_d;
    logic [2:0]  arprot_q, arprot_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_write_q, rsp_write_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic        aw_done, w_done;

`ifdef AXI_INIT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
    logic          busy, expired;

    assign busy    = state_q inside {WR, WB, RA, RD};
    assign expired = busy && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    assign timer_d = (state_q == IDLE) ? '0 : (busy ? timer_q + 1'b1 : timer_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) timer_q <= '0;
        else         timer_q <= timer_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // A channel counts as done once its valid has dropped or is handshaking this cycle.
    assign aw_done = !awvalid_q || mem_axi_awready;
    assign w_done  = !wvalid_q  || mem_axi_wready;

    always_comb begin
        state_d       = state_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        araddr_d      = araddr_q;
        arprot_d      = arprot_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                cmd_ready_d = 1'b0;
                if (cmd_write) begin
                    state_d   = WR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = {cmd_addr[31:2], 2'b00};
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                end else begin
                    state_d   = RA;
                    arvalid_d = 1'b1;
                    araddr_d  = {cmd_addr[31:2], 2'b00};
                    arprot_d  = {cmd_insn, 2'b00};
                end
            end
            WR: begin
                awvalid_d = awvalid_q && !mem_axi_awready;
                wvalid_d  = wvalid_q && !mem_axi_wready;
                if (aw_done && w_done) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end
            end
            WB: if (mem_axi_bvalid) begin
                state_d     = RSP;
                bready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b1;
                rsp_rdata_d = '0;
            end
            RA: if (mem_axi_arready) begin
                state_d   = RD;
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
            end
            RD: if (mem_axi_rvalid) begin
                state_d     = RSP;
                rready_d    = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_write_d = 1'b0;
                rsp_rdata_d = mem_axi_rdata;
            end
            RSP: if (rsp_ready) begin
                state_d       = IDLE;
                rsp_valid_d   = 1'b0;
                rsp_timeout_d = 1'b0;
                cmd_ready_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef AXI_INIT_TIMEOUT_EN
        // A transaction completing on the expiry cycle wins; otherwise abort regardless of AXI hold rules.
        if (expired && state_d != RSP) begin
            state_d       = RSP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_write_d   = (state_q == WR) || (state_q == WB);
            rsp_rdata_d   = '0;
            rsp_timeout_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cmd_ready_q   <= 1'b1;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            awaddr_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            araddr_q      <= '0;
            arprot_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            awaddr_q      <= awaddr_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            araddr_q      <= araddr_d;
            arprot_q      <= arprot_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready       = cmd_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_timeout     = rsp_timeout_q;
    assign mem_axi_awvalid = awvalid_q;
    assign mem_axi_awaddr  = awaddr_q;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_wvalid  = wvalid_q;
    assign mem_axi_wdata   = wdata_q;
    assign mem_axi_wstrb   = wstrb_q;
    assign mem_axi_bready  = bready_q;
    assign mem_axi_arvalid = arvalid_q;
    assign mem_axi_araddr  = araddr_q;
    assign mem_axi_arprot  = arprot_q;
    assign mem_axi_rready  = rready_q;
endmodule

// File: tb/tb_axi4_lite_initiator.sv
// tb_axi4_lite_initiator: directed self-checking bench with a small AXI4-lite slave memory model.
module tb_axi4_lite_initiator;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write, cmd_insn;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;

    axi4_lite_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_insn(cmd_insn),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .mem_axi_awvalid(awvalid), .mem_axi_awready(awready), .mem_axi_awaddr(awaddr), .mem_axi_awprot(awprot),
        .mem_axi_wvalid(wvalid), .mem_axi_wready(wready), .mem_axi_wdata(wdata), .mem_axi_wstrb(wstrb),
        .mem_axi_bvalid(bvalid), .mem_axi_bready(bready),
        .mem_axi_arvalid(arvalid), .mem_axi_arready(arready), .mem_axi_araddr(araddr), .mem_axi_arprot(arprot),
        .mem_axi_rvalid(rvalid), .mem_axi_rready(rready), .mem_axi_rdata(rdata)
    );

    // Slave model knobs
    int   aw_wait = 0, w_wait = 0;
    logic ar_block = 1'b0, rd_block = 1'b0, spur_b = 1'b0, spur_r = 1'b0;

    logic [31:0] mem [0:255];
    int          aw_cnt, w_cnt, b_count = 0;
    logic        aw_got, w_got, b_r, r_r;
    logic [31:0] aw_a, w_d, r_d, s_wa, s_wd;
    logic [3:0]  w_s, s_ws;
    logic        aw_hs, w_hs, s_go;

    assign awready = aw_cnt >= aw_wait;
    assign wready  = w_cnt >= w_wait;
    assign arready = !ar_block;
    assign bvalid  = b_r | spur_b;
    assign rvalid  = r_r | spur_r;
    assign rdata   = r_d;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign s_wa    = aw_got ? aw_a : awaddr;
    assign s_wd    = w_got ? w_d : wdata;
    assign s_ws    = w_got ? w_s : wstrb;
    assign s_go    = (aw_got || aw_hs) && (w_got || w_hs);

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_cnt <= 0;
            w_cnt  <= 0;
            aw_got <= 1'b0;
            w_got  <= 1'b0;
            b_r    <= 1'b0;
            r_r    <= 1'b0;
            aw_a   <= '0;
            w_d    <= '0;
            w_s    <= '0;
            r_d    <= '0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
            if (aw_hs) begin
                aw_got <= 1'b1;
                aw_a   <= awaddr;
            end
            if (w_hs) begin
                w_got <= 1'b1;
                w_d   <= wdata;
                w_s   <= wstrb;
            end
            if (b_r && bready) b_r <= 1'b0;
            if (s_go) begin
                for (int i = 0; i < 4; i++)
                    if (s_ws[i]) mem[s_wa[9:2]][8*i +: 8] <= s_wd[8*i +: 8];
                b_r    <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            if (r_r && rready) r_r <= 1'b0;
            if (arvalid && arready && !rd_block) begin
                r_r <= 1'b1;
                r_d <= mem[araddr[9:2]];
            end
        end
    end

    always @(posedge clk) if (bvalid && bready) b_count <= b_count + 1;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input string tag, input logic w, input logic insn, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, output logic [31:0] rd);
        int n;
        cmd_valid = 1'b1; cmd_write = w; cmd_insn = insn; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check({tag, "_rsp"}, {rsp_valid, rsp_write, rsp_timeout}, {1'b1, w, 1'b0});
        rd = rsp_rdata;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int n, b0;
        logic ok;
        cmd_valid = 0; cmd_write = 0; cmd_insn = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
        tick();
        tick();
        check("rst_ctl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_write, rsp_timeout}, 32'h100);
        check("rst_data", awaddr | araddr | wdata | rsp_rdata | {awprot, arprot, wstrb}, 32'h0);
        resetn = 1'b1;
        tick();

        // Zero-wait write timing
        cmd_valid = 1; cmd_write = 1; cmd_insn = 0; cmd_addr = 32'h100; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0;
        check("wr_n1_valids", {awvalid, wvalid, cmd_ready}, 32'b110);
        check("wr_awaddr", awaddr, 32'h100);
        check("wr_wdata", wdata, 32'hDEADBEEF);
        check("wr_wstrb_prot", {wstrb, awprot}, {25'd0, 4'hF, 3'b000});
        tick();
        check("wr_n2", {awvalid, wvalid, bready, rsp_valid}, 32'b0010);
        tick();
        check("wr_n3_rsp", {rsp_valid, rsp_write, bready}, 32'b110);
        check("wr_rdata", rsp_rdata, 32'h0);
        check("wr_mem", mem[8'h40], 32'hDEADBEEF);
        tick();
        check("rsp_hold", {rsp_valid, cmd_ready}, 32'b10);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("rsp_done", {rsp_valid, cmd_ready}, 32'b01);

        // Zero-wait read timing, misaligned address, instruction fetch
        cmd_valid = 1; cmd_write = 0; cmd_insn = 1; cmd_addr = 32'h102;
        tick();
        cmd_valid = 0;
        check("rd_ar", {arvalid, awvalid, wvalid}, 32'b100);
        check("rd_araddr", araddr, 32'h100);
        check("rd_arprot", {29'd0, arprot}, 32'h4);
        tick();
        check("rd_rready", {arvalid, rready}, 32'b01);
        tick();
        check("rd_rsp", {rsp_valid, rsp_write, rsp_timeout, rready}, 32'b1000);
        check("rd_rdata", rsp_rdata, 32'hDEADBEEF);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;

        // W channel stalled 5 cycles after AW
        w_wait = 5;
        b0 = b_count;
        cmd_valid = 1; cmd_write = 1; cmd_insn = 0; cmd_addr = 32'h104; cmd_wdata = 32'h12345678; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0;
        tick();
        check("stall_aw_drop", {awvalid, wvalid}, 32'b01);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            ok &= wvalid && (wdata == 32'h12345678) && (wstrb == 4'hF) && !bready;
        end
        check("stall_w_hold", {31'd0, ok}, 32'h1);
        tick();
        check("stall_w_drop", {wvalid, bready}, 32'b01);
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check("stall_rsp", {rsp_valid, rsp_write}, 32'b11);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        repeat (3) tick();
        check("stall_one_b", b_count - b0, 32'd1);
        check("stall_mem", mem[8'h41], 32'h12345678);
        w_wait = 0;

        // Byte strobe merge
        do_cmd("strb_wr", 1'b1, 1'b0, 32'h100, 32'h0000AB00, 4'b0010, rd);
        do_cmd("strb_rd", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, rd);
        check("strb_rdata", rd, 32'hDEADABEF);

        // Stray B/R valids while idle are ignored
        spur_b = 1; spur_r = 1;
        tick();
        tick();
        check("spur_ign", {cmd_ready, bready, rready, rsp_valid}, 32'b1000);
        spur_b = 0; spur_r = 0;
        tick();

        // Back-to-back with rsp_ready held high
        rsp_ready = 1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h108; cmd_wdata = 32'hCAFEF00D; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 0;
        n = 1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        check("b2b_cycles", n, 32'd4);
        rsp_ready = 0;
        check("b2b_mem", mem[8'h42], 32'hCAFEF00D);

        // Reset asserted while waiting in RD
        rd_block = 1;
        cmd_valid = 1; cmd_write = 0; cmd_insn = 1; cmd_addr = 32'h100;
        tick();
        cmd_valid = 0;
        tick();
        check("rd_wait", {arvalid, rready}, 32'b01);
        resetn = 0;
        #1;
        check("rst_mid_ctl", {cmd_ready, arvalid, rready, rsp_valid}, 32'b1000);
        check("rst_mid_data", araddr | {29'd0, arprot}, 32'h0);
        rd_block = 0;
        #2;
        resetn = 1;
        tick();
        check("rst_release", {31'd0, cmd_ready}, 32'h1);
        do_cmd("post_rst", 1'b0, 1'b0, 32'h100, 32'h0, 4'h0, rd);
        check("post_rst_rdata", rd, 32'hDEADABEF);

`ifdef AXI_INIT_TIMEOUT_EN
        // Watchdog abort of a never-accepted AR
        ar_block = 1;
        cmd_valid = 1; cmd_write = 0; cmd_insn = 0; cmd_addr = 32'h104;
        tick();
        cmd_valid = 0;
        n = 0;
        while (!rsp_valid && n < 100) begin tick(); n++; end
        check("to_cycles", n, 32'd16);
        check("to_flags", {rsp_timeout, arvalid, rsp_write}, 32'b100);
        check("to_rdata", rsp_rdata, 32'h0);
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        check("to_clear", {rsp_timeout, cmd_ready}, 32'b01);
        ar_block = 0;
        do_cmd("to_next", 1'b0, 1'b0, 32'h104, 32'h0, 4'h0, rd);
        check("to_next_rdata", rd, 32'h12345678);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axi4_lite_initiator.md
# axi4_lite_initiator

Single-outstanding AXI4-lite master that turns a simple command/response handshake into AXI4-lite read and write transactions. It is the initiator counterpart to the bench AXI memory model. It lets directed tests, DMA-style helpers and the PCPI coprocessor drive the shared AXI memory bus without the CPU core. It owns AW/W/B/AR/R sequencing and signals completion on a response port.

## Interface
- `TIMEOUT_CYCLES`, 1024: watchdog limit in cycles. Used only with `AXI_INIT_TIMEOUT_EN`.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous active-low reset.
- `cmd_valid` / `cmd_ready`  in / out  1  command handshake.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_insn`  in  1  drives `mem_axi_arprot[2]` on reads.
- `cmd_addr`  in  32  byte address.
- `cmd_wdata`  in  32  write data.
- `cmd_wstrb`  in  4  byte strobes.
- `rsp_valid` / `rsp_ready`  out / in  1  response handshake.
- `rsp_write`  out  1  echoes the `cmd_write` of the completed command.
- `rsp_rdata`  out  32  read data; 0 for writes.
- `rsp_timeout`  out  1  watchdog abort flag.
- `mem_axi_awvalid` out 1, `mem_axi_awready` in 1, `mem_axi_awaddr` out 32, `mem_axi_awprot` out 3.
- `mem_axi_wvalid` out 1, `mem_axi_wready` in 1, `mem_axi_wdata` out 32, `mem_axi_wstrb` out 4.
- `mem_axi_bvalid` in 1, `mem_axi_bready` out 1.
- `mem_axi_arvalid` out 1, `mem_axi_arready` in 1, `mem_axi_araddr` out 32, `mem_axi_arprot` out 3.
- `mem_axi_rvalid` in 1, `mem_axi_rready` out 1, `mem_axi_rdata` in 32.

## Operation
- States: IDLE, WR (AW/W phase), WB (B phase), RA (AR phase), RD (R phase), RSP.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`: latch all command fields.
  - Go to WR if `cmd_write`=1, else RA.
- Addresses are word-aligned: `{cmd_addr[31:2],2'b00}`.
- `awprot`=3'b000. `arprot`={`cmd_insn`,2'b00}.
- WR:
  - `awvalid` and `wvalid` are raised together and tracked independently by flags `aw_done` and `w_done`.
  - Each valid drops the cycle after its own handshake.
  - Either handshake may complete first, or both in the same cycle.
  - Go to WB when both flags are set.
- WB: `bready`=1. On `bvalid` go to RSP with `rsp_rdata`=0.
- RA: `arvalid`=1. On `arready` go to RD.
- RD: `rready`=1. On `rvalid` capture `rdata` and go to RSP.
- RSP:
  - `rsp_valid`=1, held with stable data until `rsp_ready`, then go to IDLE.
  - `rsp_ready` may be held high permanently.
- All AXI valids are held stable until their ready; address and data do not change while valid is high.
- Only one transaction is in flight. `cmd_ready`=0 outside IDLE.

## Timing
- Reset values: every valid/ready output 0, except `cmd_ready`=1. All addr/data/prot/strb outputs 0. `rsp_*` 0. State IDLE.
- Reset asserted mid-transaction returns to IDLE immediately and drops all valids. Partial writes are not retried.
- All outputs are registered.
- Command accepted at edge N:
  - AW/W/AR valid at N+1.
  - With zero-wait slave: B/R handshake at N+2, `rsp_valid` at N+3.
- Back-to-back: `cmd_ready` returns the cycle after the RSP handshake. Minimum 4 cycles per command.
- `bvalid`/`rvalid` arriving while not in WB/RD is ignored. That is a slave error; the bench checks it.

## Configuration
- `AXI_INIT_TIMEOUT_EN` defined:
  - A cycle counter resets on leaving IDLE and counts in WR/WB/RA/RD.
  - At `TIMEOUT_CYCLES` it forces all AXI valids/readies to 0, sets `rsp_timeout`=1 and `rsp_rdata`=0, and enters RSP.
  - This deliberately violates AXI valid-hold. It exists for debug only.
  - `rsp_timeout` clears on the RSP handshake.
- Undefined: no counter, `rsp_timeout` tied 0, waits indefinitely.

## Test plan
- Write `addr`=0x100, `wdata`=0xDEADBEEF, `wstrb`=0xF, zero-wait slave -> AW/W at N+1, `rsp_valid` at N+3 with `rsp_write`=1 and `rsp_rdata`=0. Memory word 0x40 = 0xDEADBEEF.
- Read `addr`=0x102 with `cmd_insn`=1 -> `araddr`=0x100, `arprot`=3'b100, `rsp_rdata`=0xDEADBEEF.
- Slave stalls `wready` 5 cycles after `awready` -> `awvalid` drops after 1 cycle, `wvalid` held with stable data, then exactly one B.
- Write `wstrb`=4'b0010 with `wdata`=0x0000AB00 over 0xDEADBEEF -> readback 0xDEADABEF.
- `resetn` low during RD -> all outputs at reset values in the same cycle, `cmd_ready`=1 after release.
- With `AXI_INIT_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, slave never asserts `arready` -> `rsp_valid` with `rsp_timeout`=1 after 16 cycles in RA. The next command completes normally.
